speck_iter_core: RTL and testbench

Iterative SPECK block-cipher encryption core with a parametrised word size and round count. It computes one SPECK round per clock and generates the round keys on the fly from the master key. A valid/ready handshake sits on both input and output. It is the sequential, multi-round successor to the team's single-round combinational SPECK32 datapath, and it is the unit instantiated wherever a complete SPECK encryption is needed.

---
 rtl/speck_iter_core_if.sv | 23 ++
 rtl/speck_iter_core.sv | 75 +++++++
 tb/tb_speck_iter_core.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/speck_iter_core_if.sv
// speck_iter_core_if: job/result handshake bundle; master = upstream+downstream side, slave = core side
interface speck_iter_core_if #(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [WORD_W-1:0]           pt_x;
  logic [WORD_W-1:0]           pt_y;
  logic [KEY_WORDS*WORD_W-1:0] key_in;
  logic                        out_valid;
  logic                        out_ready;
  logic [WORD_W-1:0]           ct_x;
  logic [WORD_W-1:0]           ct_y;
  modport master (
    output in_valid, pt_x, pt_y, key_in, out_ready,
    input  in_ready, out_valid, ct_x, ct_y
  );
  modport slave (
    input  in_valid, pt_x, pt_y, key_in, out_ready,
    output in_ready, out_valid, ct_x, ct_y
  );
endinterface

// File: rtl/speck_iter_core.sv
// speck_iter_core: iterative SPECK encryptor, one round per clk with on-the-fly key schedule; ports clk, rst_n (sync active-low), s (slave: in_valid/in_ready/pt_x/pt_y/key_in in, out_valid/out_ready/ct_x/ct_y out); SPECK_DEBUG_KEY_EN adds debug_key/debug_round
module speck_iter_core #(
  parameter int WORD_W    = 16,
  parameter int KEY_WORDS = 4,
  parameter int ROUNDS    = 22
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef SPECK_DEBUG_KEY_EN
  output logic [WORD_W-1:0]            debug_key,
  output logic [$clog2(ROUNDS+1)-1:0]  debug_round,
`endif
  speck_iter_core_if.slave             s
);
  localparam int A  = WORD_W == 16 ? 7 : 8;
  localparam int B  = WORD_W == 16 ? 2 : 3;
  localparam int CW = $clog2(ROUNDS + 1);
  localparam int LW = (KEY_WORDS - 1) * WORD_W;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [WORD_W-1:0] x, y, k, x_n, y_n, k_n, l_new;
  logic [LW-1:0]     l, l_sh;
  logic [CW-1:0]     i;
  logic              last;
  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] v, input int r);
    return (v >> r) | (v << (WORD_W - r));
  endfunction
  always_comb begin
    x_n   = (ror(x, A) + y) ^ k;
    y_n   = ror(y, WORD_W - B) ^ x_n;
    l_new = (k + ror(l[WORD_W-1:0], A)) ^ WORD_W'(i);
    k_n   = ror(k, WORD_W - B) ^ l_new;
    l_sh  = LW'({l_new, l} >> WORD_W);
    last  = i == CW'(ROUNDS - 1);
  end
  // k/l/i freeze on the final round so k and i still show the last round's values in DONE
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      l     <= '0;
      i     <= '0;
    end else case (state)
      IDLE: if (s.in_valid) begin
        x     <= s.pt_x;
        y     <= s.pt_y;
        k     <= s.key_in[WORD_W-1:0];
        l     <= s.key_in[KEY_WORDS*WORD_W-1:WORD_W];
        i     <= '0;
        state <= RUN;
      end
      RUN: begin
        x <= x_n;
        y <= y_n;
        if (last) state <= DONE;
        else begin
          k <= k_n;
          l <= l_sh;
          i <= i + CW'(1);
        end
      end
      DONE: if (s.out_ready) state <= IDLE;
      default: state <= IDLE;
    endcase
  assign s.in_ready  = state == IDLE;
  assign s.out_valid = state == DONE;
  assign s.ct_x      = x;
  assign s.ct_y      = y;
`ifdef SPECK_DEBUG_KEY_EN
  assign debug_key   = state == IDLE ? '0 : k;
  assign debug_round = state == IDLE ? '0 : i;
`endif
endmodule

// File: tb/tb_speck_iter_core.sv
// tb_speck_iter_core: directed vectors, array-based SPECK reference model and per-cycle handshake/result checker
module tb_speck_iter_core;
  localparam int R = 22;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  int checks = 0, passes = 0, cyc = 0;
  always @(posedge clk) cyc++;
  speck_iter_core_if #(.WORD_W(16), .KEY_WORDS(4)) bus();
  speck_iter_core_if #(.WORD_W(32), .KEY_WORDS(4)) bus2();
`ifdef SPECK_DEBUG_KEY_EN
  logic [15:0] debug_key;
  logic [4:0]  debug_round;
  logic [31:0] dk2;
  logic [4:0]  dr2;
`endif
  speck_iter_core #(.WORD_W(16), .KEY_WORDS(4), .ROUNDS(R)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SPECK_DEBUG_KEY_EN
    .debug_key(debug_key),
    .debug_round(debug_round),
`endif
    .s(bus.slave)
  );
  speck_iter_core #(.WORD_W(32), .KEY_WORDS(4), .ROUNDS(27)) dut2 (
    .clk(clk),
    .rst_n(rst_n),
`ifdef SPECK_DEBUG_KEY_EN
    .debug_key(dk2),
    .debug_round(dr2),
`endif
    .s(bus2.slave)
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  function automatic logic [63:0] rr(input logic [63:0] v, input int r, input int n);
    return ((v >> r) | (v << (n - r))) & ((64'd1 << n) - 1);
  endfunction

  // Reference SPECK: full round-key array first (l[i+m-1], k[i+1] from k[i], l[i]), then the rounds
  function automatic void speck(input int n, input int m, input int t, input logic [63:0] px, input logic [63:0] py,
                                input logic [127:0] key, output logic [63:0] cx, output logic [63:0] cy);
    logic [63:0] msk, xx, yy;
    logic [63:0] kk[64];
    logic [63:0] ll[128];
    int a, b;
    msk = (64'd1 << n) - 1;
    a = n == 16 ? 7 : 8;
    b = n == 16 ? 2 : 3;
    kk[0] = key[63:0] & msk;
    for (int j = 0; j < m - 1; j++) ll[j] = 64'(key >> (n * (j + 1))) & msk;
    for (int j = 0; j < t - 1; j++) begin
      ll[j+m-1] = ((kk[j] + rr(ll[j], a, n)) & msk) ^ 64'(j);
      kk[j+1]   = rr(kk[j], n - b, n) ^ ll[j+m-1];
    end
    xx = px;
    yy = py;
    for (int j = 0; j < t; j++) begin
      xx = ((rr(xx, a, n) + yy) & msk) ^ kk[j];
      yy = rr(yy, n - b, n) ^ xx;
    end
    cx = xx;
    cy = yy;
  endfunction

  // Per-cycle checker: 0 idle, 1 running (left = edges to go), 2 result presented
  int st = 0, left = 0;
  bit zero = 1;
  logic [15:0] qx[$], qy[$];
  always @(negedge clk) begin
    logic [63:0] ex, ey;
    chk("in_ready", bus.in_ready, st == 0);
    chk("out_valid", bus.out_valid, st == 2);
    if (st == 2 && qx.size() > 0) begin
      chk("ct_x", bus.ct_x, qx[0]);
      chk("ct_y", bus.ct_y, qy[0]);
    end else if (zero) begin
      chk("ct_x zero", bus.ct_x, 0);
      chk("ct_y zero", bus.ct_y, 0);
    end
    if (!rst_n) begin
      st = 0;
      zero = 1;
      qx.delete();
      qy.delete();
    end else if (st == 0) begin
      if (bus.in_valid) begin
        speck(16, 4, R, bus.pt_x, bus.pt_y, bus.key_in, ex, ey);
        qx.push_back(ex[15:0]);
        qy.push_back(ey[15:0]);
        st = 1;
        left = R;
        zero = 0;
      end
    end else if (st == 1) begin
      left--;
      if (left == 0) st = 2;
    end else if (bus.out_ready) begin
      void'(qx.pop_front());
      void'(qy.pop_front());
      st = 0;
    end
  end

  task automatic send(input logic [15:0] px, input logic [15:0] py, input logic [63:0] key, output int acc_c);
    bit acc = 0;
    bus.pt_x = px;
    bus.pt_y = py;
    bus.key_in = key;
    bus.in_valid = 1;
    for (int c = 0; c < 200 && !acc; c++) begin
      acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 0;
    acc_c = cyc;
    chk("accept", acc, 1);
  endtask

  task automatic wait_ov(output int c_ov);
    for (int c = 0; c < 200 && !bus.out_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("out_valid timeout", bus.out_valid, 1);
    c_ov = cyc;
  endtask

  logic [63:0] mx, my;
  logic [15:0] hx, hy;
  int a, o, nacc;
  int acc_t[2];
  bit seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.pt_x = 0; bus.pt_y = 0; bus.key_in = 0; bus.out_ready = 1;
    bus2.in_valid = 0; bus2.pt_x = 0; bus2.pt_y = 0; bus2.key_in = 0; bus2.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("reset in_ready", bus.in_ready, 1);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset ct_x", bus.ct_x, 0);
    chk("reset ct_y", bus.ct_y, 0);
    speck(16, 4, 22, 'h6574, 'h694c, 'h1918111009080100, mx, my);
    chk("model32 x", mx, 'ha868);
    chk("model32 y", my, 'h42f2);
    speck(32, 4, 27, 'h3b726574, 'h7475432d, 128'h1b1a1918_13121110_0b0a0908_03020100, mx, my);
    chk("model64 x", mx, 'h8c6fa548);
    chk("model64 y", my, 'h454e028b);

    // SPECK64/128 on the 32-bit instance
    bus2.pt_x = 32'h3b726574;
    bus2.pt_y = 32'h7475432d;
    bus2.key_in = 128'h1b1a1918_13121110_0b0a0908_03020100;
    chk("speck64 in_ready", bus2.in_ready, 1);
    bus2.in_valid = 1;
    @(posedge clk); #1;
    bus2.in_valid = 0;
    a = cyc;
    for (int c = 0; c < 200 && !bus2.out_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("speck64 latency", cyc - a, 27);
    chk("speck64 ct_x", bus2.ct_x, 'h8c6fa548);
    chk("speck64 ct_y", bus2.ct_y, 'h454e028b);
    @(posedge clk); #1;

    // SPECK32/64 vector, out_ready already high
    send(16'h6574, 16'h694c, 64'h1918_1110_0908_0100, a);
`ifdef SPECK_DEBUG_KEY_EN
    chk("debug_key round0", debug_key, 'h0100);
    chk("debug_round 0", debug_round, 0);
    for (int r = 1; r < R; r++) begin
      @(posedge clk); #1;
      chk("debug_round", debug_round, r);
    end
`endif
    wait_ov(o);
    chk("speck32 latency", o - a, R);
    chk("speck32 ct_x", bus.ct_x, 'ha868);
    chk("speck32 ct_y", bus.ct_y, 'h42f2);
    @(posedge clk); #1;
    chk("done one cycle", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("in_ready after done", bus.in_ready, 1);

    // Output backpressure: result holds, new requests ignored
    bus.out_ready = 0;
    send(16'h1234, 16'h5678, 64'h0123_4567_89ab_cdef, a);
    wait_ov(o);
    hx = bus.ct_x;
    hy = bus.ct_y;
    bus.pt_x = 16'hffff; bus.pt_y = 16'hffff; bus.key_in = '1; bus.in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold ct_x", bus.ct_x, hx);
      chk("hold ct_y", bus.ct_y, hy);
      chk("hold in_ready", bus.in_ready, 0);
      chk("hold out_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1;
    send(16'hffff, 16'hffff, '1, a);
    wait_ov(o);
    speck(16, 4, R, 'hffff, 'hffff, 64'hffff_ffff_ffff_ffff, mx, my);
    chk("after hold ct_x", bus.ct_x, mx);
    chk("after hold ct_y", bus.ct_y, my);
    @(posedge clk); #1;

    // Back-to-back with in_valid held high
    nacc = 0;
    bus.pt_x = 0; bus.pt_y = 0; bus.key_in = 0; bus.in_valid = 1;
    for (int c = 0; c < 200 && nacc < 2; c++) begin
      seen = bus.in_ready;
      @(posedge clk); #1;
      if (seen) begin
        acc_t[nacc] = cyc;
        nacc++;
        bus.pt_x = 16'h6574; bus.pt_y = 16'h694c; bus.key_in = 64'h1918_1110_0908_0100;
      end
    end
    bus.in_valid = 0;
    chk("b2b accepts", nacc, 2);
    chk("b2b spacing", acc_t[1] - acc_t[0], R + 2);
    wait_ov(o);
    chk("b2b ct_x", bus.ct_x, 'ha868);
    chk("b2b ct_y", bus.ct_y, 'h42f2);
    @(posedge clk); #1;

    // Reset while round 10 is pending
    send(16'h1234, 16'h5678, 64'h0123_4567_89ab_cdef, a);
    repeat (10) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk("abort out_valid", bus.out_valid, 0);
    chk("abort ct_x", bus.ct_x, 0);
    chk("abort ct_y", bus.ct_y, 0);
    chk("abort in_ready", bus.in_ready, 1);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      seen |= bus.out_valid;
    end
    chk("aborted job silent", seen, 0);
    send(16'habcd, 16'h0001, 64'hfedc_ba98_7654_3210, a);
    wait_ov(o);
    speck(16, 4, R, 'habcd, 'h0001, 64'hfedc_ba98_7654_3210, mx, my);
    chk("post-reset latency", o - a, R);
    chk("post-reset ct_x", bus.ct_x, mx);
    chk("post-reset ct_y", bus.ct_y, my);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
